// File: rtl/drop_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : drop_controller                                              |
// | Description : Takes a column drop request, finds the landing row from the  |
// |               per-column fill heights, issues one valid/ready board write  |
// |               and then pulses turn_adv for the turn tracker.               |
// |               Optional macro BOARD_FULL_DETECT_EN adds a piece counter and |
// |               the board_full output.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module drop_controller #(
    parameter int COLS  = 7,
    parameter int ROWS  = 6,
    parameter int COL_W = 3,
    parameter int ROW_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             drop_req,
    input  logic [COL_W-1:0] drop_col,
    input  logic [1:0]       player,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic [1:0]       wr_colour,
    output logic             turn_adv,
    output logic             reject,
    output logic             busy
`ifdef BOARD_FULL_DETECT_EN
    ,
    output logic             board_full
`endif
);

    localparam logic [COL_W:0]   c_cols = (COL_W+1)'(COLS);
    localparam logic [ROW_W-1:0] c_rows = ROW_W'(ROWS);
    localparam logic [ROW_W-1:0] c_one  = ROW_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_WRITE   = 3'd2,
        S_REJECT  = 3'd3,
        S_ADVANCE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [COL_W-1:0] r_col;
    logic [1:0]       r_player;
    logic [ROW_W-1:0] r_height [COLS];
    logic [ROW_W-1:0] r_wr_row;
    logic             r_wr_valid;
    logic             r_turn_adv;
    logic             r_reject;
    logic             r_busy;

    logic [ROW_W-1:0] w_height_sel;
    logic             w_col_ok;
    logic             w_col_full;
    logic             w_player_ok;
    logic             w_board_full;
    logic             w_refuse;
    logic             w_accept;
    logic             w_wr_valid_d;
    logic             w_turn_adv_d;
    logic             w_reject_d;
    logic             w_busy_d;

    // Out-of-range columns select height 0; they are refused by w_col_ok anyway.
    always_comb begin
        w_height_sel = '0;
        for (int c = 0; c < COLS; c++) begin
            if (r_col == COL_W'(c)) begin
                w_height_sel = r_height[c];
            end
        end
    end

    assign w_col_ok    = ({1'b0, r_col} < c_cols);
    assign w_col_full  = (w_height_sel == c_rows);
    assign w_player_ok = (r_player == 2'b01) || (r_player == 2'b10);
    assign w_refuse    = !w_col_ok || w_col_full || !w_player_ok || w_board_full;
    assign w_accept    = r_wr_valid && wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus the next value of every registered strobe.
    always_comb begin
        w_next       = r_state;
        w_wr_valid_d = 1'b0;
        w_turn_adv_d = 1'b0;
        w_reject_d   = 1'b0;
        w_busy_d     = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (drop_req) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_next = w_refuse ? S_REJECT : S_WRITE;
            end
            S_WRITE: begin
                if (w_accept) begin
                    w_next = S_ADVANCE;
                end
            end
            S_REJECT: begin
                w_next = S_IDLE;
            end
            S_ADVANCE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        w_wr_valid_d = (w_next == S_WRITE);
        w_turn_adv_d = (w_next == S_ADVANCE);
        w_reject_d   = (w_next == S_REJECT);
        w_busy_d     = (w_next != S_IDLE);
    end

    // Strobes come straight from flops so downstream enables see no glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_valid <= 1'b0;
            r_turn_adv <= 1'b0;
            r_reject   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_wr_valid <= w_wr_valid_d;
            r_turn_adv <= w_turn_adv_d;
            r_reject   <= w_reject_d;
            r_busy     <= w_busy_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col    <= '0;
            r_player <= '0;
            r_wr_row <= '0;
        end else begin
            if (r_state == S_IDLE && drop_req) begin
                r_col    <= drop_col;
                r_player <= player;
            end
            if (r_state == S_CHECK) begin
                r_wr_row <= w_height_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < COLS; c++) begin
                r_height[c] <= '0;
            end
        end else if (w_accept) begin
            for (int c = 0; c < COLS; c++) begin
                if (r_col == COL_W'(c) && r_height[c] != c_rows) begin
                    r_height[c] <= r_height[c] + c_one;
                end
            end
        end
    end

`ifdef BOARD_FULL_DETECT_EN
    localparam int               c_cnt_w    = $clog2(ROWS*COLS + 1);
    localparam logic [c_cnt_w-1:0] c_cells    = c_cnt_w'(ROWS*COLS);
    localparam logic [c_cnt_w-1:0] c_cells_m1 = c_cnt_w'(ROWS*COLS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_pieces;
    logic               r_board_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pieces     <= '0;
            r_board_full <= 1'b0;
        end else if (w_accept && r_pieces != c_cells) begin
            r_pieces <= r_pieces + c_cnt_one;
            if (r_pieces == c_cells_m1) begin
                r_board_full <= 1'b1;
            end
        end
    end

    assign w_board_full = r_board_full;
    assign board_full   = r_board_full;
`else
    assign w_board_full = 1'b0;
`endif

    assign wr_valid  = r_wr_valid;
    assign wr_row    = r_wr_row;
    assign wr_col    = r_col;
    assign wr_colour = r_player;
    assign turn_adv  = r_turn_adv;
    assign reject    = r_reject;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_drop_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_drop_controller                                           |
// | Description : Table-driven bench for drop_controller plus hand sequences   |
// |               for stall, reset-in-WRITE and (optionally) board-full.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_drop_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       drop_req;
    logic [2:0] drop_col;
    logic [1:0] player;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic [1:0] wr_colour;
    logic       turn_adv;
    logic       reject;
    logic       busy;
`ifdef BOARD_FULL_DETECT_EN
    logic       board_full;
`endif

    int checks   = 0;
    int failures = 0;

    drop_controller #(.COLS(7), .ROWS(6), .COL_W(3), .ROW_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .drop_req  (drop_req),
        .drop_col  (drop_col),
        .player    (player),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_colour (wr_colour),
        .turn_adv  (turn_adv),
        .reject    (reject),
        .busy      (busy)
`ifdef BOARD_FULL_DETECT_EN
        ,
        .board_full(board_full)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] col;
        logic [1:0] colour;
        int         stall;
        bit         rej;
        int         row;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full drop transaction; stall = cycles wr_ready is held low under wr_valid.
    task automatic do_drop(input logic [2:0] col, input logic [1:0] pl, input int stall,
                           input bit rej, input int row, input string tag);
        int vcnt = 0, rcnt = 0, tcnt = 0;
        int t_valid = 0, t_turn = 0, t_idle = 0, t_rej = 0;
        bit stable = 1'b1, done = 1'b0, still_idle = 1'b1;
        logic [2:0] cap_row = '0, cap_col = '0;
        logic [1:0] cap_colour = '0;
        wr_ready = (stall == 0);
        drop_col = col;
        player   = pl;
        drop_req = 1'b1;
        step();
        drop_req = 1'b0;
        player   = ~pl;
        drop_col = 3'd5;
        for (int k = 1; k <= 40 && !done; k++) begin
            if (k > 1) step();
            drop_req = 1'b0;
            if (wr_valid) begin
                vcnt++;
                if (vcnt == 1) begin
                    t_valid = k; cap_row = wr_row; cap_col = wr_col; cap_colour = wr_colour;
                end else if (wr_row !== cap_row || wr_col !== cap_col || wr_colour !== cap_colour) begin
                    stable = 1'b0;
                end
                if (vcnt > stall) begin
                    wr_ready = 1'b1;
                end else if (vcnt % 2 == 1) begin
                    drop_req = 1'b1;
                    drop_col = 3'd0;
                end
            end
            if (reject)   begin rcnt++; t_rej = k;  end
            if (turn_adv) begin tcnt++; t_turn = k; end
            if (!busy)    begin done = 1'b1; t_idle = k; end
        end
        chk({tag, "_finished"}, done, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            if (busy || wr_valid || turn_adv || reject) still_idle = 1'b0;
        end
        chk({tag, "_stays_idle"}, still_idle, 1'b1);
        if (rej) begin
            chk({tag, "_reject_cnt"}, rcnt, 1);
            chk({tag, "_reject_at"}, t_rej, 2);
            chk({tag, "_valid_cnt"}, vcnt, 0);
            chk({tag, "_turn_cnt"}, tcnt, 0);
            chk({tag, "_idle_at"}, t_idle, 3);
        end else begin
            chk({tag, "_reject_cnt"}, rcnt, 0);
            chk({tag, "_valid_cnt"}, vcnt, stall + 1);
            chk({tag, "_valid_at"}, t_valid, 2);
            chk({tag, "_row"}, cap_row, row);
            chk({tag, "_col"}, cap_col, col);
            chk({tag, "_colour"}, cap_colour, pl);
            chk({tag, "_stable"}, stable, 1'b1);
            chk({tag, "_turn_cnt"}, tcnt, 1);
            chk({tag, "_turn_at"}, t_turn, 3 + stall);
            chk({tag, "_idle_at"}, t_idle, 4 + stall);
        end
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bit found;
        vecs[0]  = '{3'd3, 2'b01, 0, 1'b0, 0};
        vecs[1]  = '{3'd2, 2'b10, 0, 1'b0, 0};
        vecs[2]  = '{3'd2, 2'b01, 0, 1'b0, 1};
        vecs[3]  = '{3'd2, 2'b10, 0, 1'b0, 2};
        vecs[4]  = '{3'd2, 2'b01, 0, 1'b0, 3};
        vecs[5]  = '{3'd2, 2'b10, 0, 1'b0, 4};
        vecs[6]  = '{3'd2, 2'b01, 0, 1'b0, 5};
        vecs[7]  = '{3'd2, 2'b10, 0, 1'b1, 0};
        vecs[8]  = '{3'd7, 2'b01, 0, 1'b1, 0};
        vecs[9]  = '{3'd3, 2'b10, 0, 1'b0, 1};
        vecs[10] = '{3'd0, 2'b00, 0, 1'b1, 0};
        vecs[11] = '{3'd0, 2'b11, 0, 1'b1, 0};
        vecs[12] = '{3'd0, 2'b01, 5, 1'b0, 0};
        vecs[13] = '{3'd2, 2'b10, 0, 1'b1, 0};
        vecs[14] = '{3'd6, 2'b10, 2, 1'b0, 0};

        reset    = 1'b1;
        drop_req = 1'b0;
        drop_col = '0;
        player   = 2'b01;
        wr_ready = 1'b1;
        step();
        step();
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_row", wr_row, 0);
        chk("rst_wr_col", wr_col, 0);
        chk("rst_wr_colour", wr_colour, 0);
        chk("rst_turn_adv", turn_adv, 0);
        chk("rst_reject", reject, 0);
        chk("rst_busy", busy, 0);
`ifdef BOARD_FULL_DETECT_EN
        chk("rst_board_full", board_full, 0);
`endif
        reset = 1'b0;
        step();

        for (int i = 0; i < 15; i++) begin
            do_drop(vecs[i].col, vecs[i].colour, vecs[i].stall, vecs[i].rej, vecs[i].row,
                    $sformatf("vec%0d", i));
        end

        // Reset while a write is pending: column 6 holds one piece here.
        wr_ready = 1'b0;
        drop_col = 3'd6;
        player   = 2'b01;
        drop_req = 1'b1;
        step();
        drop_req = 1'b0;
        found    = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (wr_valid) found = 1'b1;
        end
        chk("rstw_valid_seen", found, 1'b1);
        chk("rstw_row_before", wr_row, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstw_valid_drop", wr_valid, 0);
        chk("rstw_busy_drop", busy, 0);
        chk("rstw_turn_adv", turn_adv, 0);
        step();
        chk("rstw_turn_adv_held", turn_adv, 0);
        reset    = 1'b0;
        wr_ready = 1'b1;
        step();
        chk("rstw_turn_after", turn_adv, 0);
        do_drop(3'd6, 2'b10, 0, 1'b0, 0, "rstw_col6");
        do_drop(3'd2, 2'b01, 0, 1'b0, 0, "rstw_col2");
        do_drop(3'd3, 2'b10, 0, 1'b0, 0, "rstw_col3");

`ifdef BOARD_FULL_DETECT_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("full_init", board_full, 0);
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                if (c == 6 && r == 5) chk("full_before_last", board_full, 0);
                do_drop(3'(c), (r % 2 == 0) ? 2'b01 : 2'b10, 0, 1'b0, r,
                        $sformatf("fill_c%0d_r%0d", c, r));
            end
        end
        chk("full_after_42", board_full, 1);
        do_drop(3'd0, 2'b01, 0, 1'b1, 0, "full_reject");
        chk("full_holds", board_full, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
